rgb_pwm_array: RTL and testbench

Parametrised multi-channel RGB LED driver and successor to the single-LED controller. It drives NUM_LEDS RGB LEDs, each with its own per-colour PWM duty and per-LED mode: static, blink, breathe or off. Duty and mode values sit in shadow registers and are applied only at PWM period boundaries, so outputs never glitch. The top level instantiates it between the switch/register inputs and the board RGB pins.

---
 rtl/rgb_pwm_array_if.sv | 24 ++
 rtl/rgb_pwm_array.sv | 148 ++++++++++++++
 tb/tb_rgb_pwm_array.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/rgb_pwm_array_if.sv
// Register-side bundle for rgb_pwm_array: duty/mode inputs with load strobe,
// plus the per-LED colour outputs and the period-start pulse.
interface rgb_pwm_array_if #(
  parameter int NUM_LEDS = 2,
  parameter int PWM_BITS = 4
);
  logic [NUM_LEDS*3*PWM_BITS-1:0] dutyIn;
  logic [2*NUM_LEDS-1:0]          modeIn;
  logic                           load;
  logic [NUM_LEDS-1:0]            rLED;
  logic [NUM_LEDS-1:0]            gLED;
  logic [NUM_LEDS-1:0]            bLED;
  logic                           periodStart;

  modport master (
    output dutyIn, modeIn, load,
    input  rLED, gLED, bLED, periodStart
  );

  modport slave (
    input  dutyIn, modeIn, load,
    output rLED, gLED, bLED, periodStart
  );
endinterface

// File: rtl/rgb_pwm_array.sv
// Multi-LED RGB PWM driver with static/blink/breathe/off modes; duty and mode
// are double-buffered and only take effect at PWM period boundaries.
module rgb_pwm_array #(
  parameter int NUM_LEDS      = 2,
  parameter int PWM_BITS      = 4,
  parameter int PRESCALE      = 1,
  parameter int BLINK_PERIODS = 2
) (
  input  logic           clk,
  input  logic           rst,
  rgb_pwm_array_if.slave bus
);
  localparam int B     = PWM_BITS;
  localparam int CH    = 3 * NUM_LEDS;
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BLK_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;

  localparam logic [B-1:0]     CNT_LAST = B'((1 << B) - 2);
  localparam logic [B-1:0]     ENV_MAX  = B'((1 << B) - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_PERIODS - 1);

  localparam logic [1:0] MODE_STATIC  = 2'b00;
  localparam logic [1:0] MODE_BLINK   = 2'b01;
  localparam logic [1:0] MODE_BREATHE = 2'b10;
  localparam logic [1:0] MODE_OFF     = 2'b11;

  logic [PRE_W-1:0]      pre_cnt_reg;
  logic [B-1:0]          pwm_cnt_reg;
  logic [CH*B-1:0]       shadow_duty_reg;
  logic [2*NUM_LEDS-1:0] shadow_mode_reg;
  logic [CH*B-1:0]       active_duty_reg;
  logic [2*NUM_LEDS-1:0] active_mode_reg;
  logic [BLK_W-1:0]      blink_cnt_reg;
  logic                  blink_on_reg;
  logic [B-1:0]          env_reg;
  logic                  dir_down_reg;
  logic [NUM_LEDS-1:0]   r_led_reg;
  logic [NUM_LEDS-1:0]   g_led_reg;
  logic [NUM_LEDS-1:0]   b_led_reg;
  logic                  period_start_reg;

  logic                  tick;
  logic                  boundary;
  logic [CH-1:0]         pwm_on;
  logic [NUM_LEDS-1:0]   r_led_next;
  logic [NUM_LEDS-1:0]   g_led_next;
  logic [NUM_LEDS-1:0]   b_led_next;

  assign tick     = (pre_cnt_reg == PRE_LAST);
  assign boundary = tick && (pwm_cnt_reg == CNT_LAST);

  genvar gi;

  // One comparator per colour channel; channel index = 3*led + colour.
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic [B-1:0]   duty;
      logic [1:0]     mode;
      logic [2*B-1:0] scaled;
      logic [B-1:0]   eff_duty;

      assign duty   = active_duty_reg[gi*B +: B];
      assign mode   = active_mode_reg[(gi/3)*2 +: 2];
      assign scaled = {{B{1'b0}}, duty} * {{B{1'b0}}, env_reg};

      always_comb begin
        eff_duty = '0;
        unique case (mode)
          MODE_STATIC:  eff_duty = duty;
          MODE_BLINK:   eff_duty = blink_on_reg ? duty : '0;
          MODE_BREATHE: eff_duty = B'(scaled >> B);
          MODE_OFF:     eff_duty = '0;
        endcase
      end

      assign pwm_on[gi] = (pwm_cnt_reg < eff_duty);
    end

    for (gi = 0; gi < NUM_LEDS; gi++) begin : g_led
      assign r_led_next[gi] = pwm_on[3*gi];
      assign g_led_next[gi] = pwm_on[3*gi+1];
      assign b_led_next[gi] = pwm_on[3*gi+2];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_reg      <= '0;
      pwm_cnt_reg      <= '0;
      shadow_duty_reg  <= '0;
      shadow_mode_reg  <= '0;
      active_duty_reg  <= '0;
      active_mode_reg  <= '0;
      blink_cnt_reg    <= '0;
      blink_on_reg     <= 1'b1;
      env_reg          <= '0;
      dir_down_reg     <= 1'b0;
      r_led_reg        <= '0;
      g_led_reg        <= '0;
      b_led_reg        <= '0;
      period_start_reg <= 1'b0;
    end else begin
      pre_cnt_reg <= tick ? '0 : pre_cnt_reg + 1'b1;

      if (bus.load) begin
        shadow_duty_reg <= bus.dutyIn;
        shadow_mode_reg <= bus.modeIn;
      end

      if (tick) begin
        pwm_cnt_reg <= (pwm_cnt_reg == CNT_LAST) ? '0 : pwm_cnt_reg + 1'b1;
      end

      if (boundary) begin
        // A load landing on the boundary itself goes straight to the active set.
        active_duty_reg <= bus.load ? bus.dutyIn : shadow_duty_reg;
        active_mode_reg <= bus.load ? bus.modeIn : shadow_mode_reg;

        if (blink_cnt_reg == BLK_LAST) begin
          blink_cnt_reg <= '0;
          blink_on_reg  <= ~blink_on_reg;
        end else begin
          blink_cnt_reg <= blink_cnt_reg + 1'b1;
        end

        // Envelope holds for one step at each end while the direction flips.
        if (!dir_down_reg) begin
          if (env_reg == ENV_MAX) dir_down_reg <= 1'b1;
          else                    env_reg      <= env_reg + 1'b1;
        end else begin
          if (env_reg == '0) dir_down_reg <= 1'b0;
          else               env_reg      <= env_reg - 1'b1;
        end
      end

      period_start_reg <= boundary;
      r_led_reg        <= r_led_next;
      g_led_reg        <= g_led_next;
      b_led_reg        <= b_led_next;
    end
  end

  assign bus.rLED        = r_led_reg;
  assign bus.gLED        = g_led_reg;
  assign bus.bLED        = b_led_reg;
  assign bus.periodStart = period_start_reg;
endmodule

// File: tb/tb_rgb_pwm_array.sv
// Scoreboard bench for rgb_pwm_array: a period-level model predicts each
// channel's effective duty; a monitor checks every PWM period's waveform.
module tb_rgb_pwm_array;
  localparam int NL  = 2;
  localparam int B   = 4;
  localparam int BP  = 2;
  localparam int PER = 15;
  localparam int CH  = 3 * NL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  rgb_pwm_array_if #(.NUM_LEDS(NL), .PWM_BITS(B)) bus ();
  rgb_pwm_array_if #(.NUM_LEDS(NL), .PWM_BITS(B)) bus3 ();

  rgb_pwm_array #(.NUM_LEDS(NL), .PWM_BITS(B), .PRESCALE(1), .BLINK_PERIODS(BP)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  rgb_pwm_array #(.NUM_LEDS(NL), .PWM_BITS(B), .PRESCALE(3), .BLINK_PERIODS(BP)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3)
  );

  assign bus3.dutyIn = bus.dutyIn;
  assign bus3.modeIn = bus.modeIn;
  assign bus3.load   = bus.load;

  always #5 clk = ~clk;

  // Reference model state: period position, shadow/active sets, boundaries since reset.
  logic [CH*B-1:0]   sh_d, act_d;
  logic [2*NL-1:0]   sh_m, act_m;
  int                nb  = 0;
  int                pos = 0;
  logic [CH*B-1:0]   q[$];

  function automatic logic [CH*B-1:0] model_eff();
    logic [CH*B-1:0] e;
    int n, env, d, md;
    bit on;
    e   = '0;
    n   = nb % 32;
    env = (n <= 15) ? n : 31 - n;
    on  = ((nb / BP) % 2) == 0;
    for (int ch = 0; ch < CH; ch++) begin
      d  = int'(act_d[ch*B +: B]);
      md = int'(act_m[(ch/3)*2 +: 2]);
      case (md)
        0:       e[ch*B +: B] = B'(d);
        1:       e[ch*B +: B] = on ? B'(d) : '0;
        2:       e[ch*B +: B] = B'((d * env) / 16);
        default: e[ch*B +: B] = '0;
      endcase
    end
    return e;
  endfunction

  task automatic cycle(input bit ld, input logic [CH*B-1:0] d, input logic [2*NL-1:0] m, input bit r);
    rst        = r;
    bus.load   = ld;
    bus.dutyIn = d;
    bus.modeIn = m;
    if (r) begin
      sh_d = '0; sh_m = '0; act_d = '0; act_m = '0; nb = 0; pos = 0;
    end else begin
      if (ld) begin
        sh_d = d;
        sh_m = m;
      end
      if (pos == PER - 1) begin
        act_d = sh_d;
        act_m = sh_m;
        nb++;
        q.push_back(model_eff());
      end
      pos = (pos == PER - 1) ? 0 : pos + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, bus.dutyIn, bus.modeIn, 1'b0);
  endtask

  task automatic load_at(input int target, input logic [CH*B-1:0] d, input logic [2*NL-1:0] m);
    while (pos != target) idle(1);
    cycle(1'b1, d, m, 1'b0);
  endtask

  task automatic random_run(input int n);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 5) == 0) cycle(1'b1, 24'($urandom), 4'($urandom), 1'b0);
      else                          idle(1);
    end
  endtask

  // Monitor: each periodStart opens a 15-sample window checked against the queued duties.
  logic [CH*B-1:0] cur_exp;
  logic [PER-1:0]  cap [CH];
  int              idx = 0;
  bit              capturing = 0;
  int              periods_checked = 0;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      cur_exp   = '0;
      idx       = 0;
      capturing = 1;
    end else begin
      if (capturing && idx < PER) begin
        for (int i = 0; i < NL; i++) begin
          cap[3*i][idx]   = bus.rLED[i];
          cap[3*i+1][idx] = bus.gLED[i];
          cap[3*i+2][idx] = bus.bLED[i];
        end
        idx++;
        if (idx == PER) begin
          for (int ch = 0; ch < CH; ch++) begin
            logic [PER-1:0] want;
            int d;
            d = int'(cur_exp[ch*B +: B]);
            for (int k = 0; k < PER; k++) want[k] = (k < d);
            tests++;
            if (cap[ch] !== want) begin
              fails++;
              $display("FAIL period%0d led%0d colour%0d waveform got %b want %b (duty %0d)",
                       periods_checked, ch / 3, ch % 3, cap[ch], want, d);
            end
          end
          periods_checked++;
          capturing = 0;
        end
      end
      if (bus.periodStart) begin
        if (capturing) begin
          tests++; fails++;
          $display("FAIL early_period_start got sample count %0d want %0d", idx, PER);
        end
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_period_start got pulse want none (queue empty)");
          capturing = 0;
        end else begin
          cur_exp   = q.pop_front();
          idx       = 0;
          capturing = 1;
        end
      end
    end
  end

  // Period length of the PRESCALE=3 instance.
  int gap3 = 0;
  bit seen3 = 0;
  always @(negedge clk) begin
    if (rst) begin
      seen3 = 0;
      gap3  = 0;
    end else begin
      gap3++;
      if (bus3.periodStart) begin
        if (seen3) begin
          tests++;
          if (gap3 != 45) begin
            fails++;
            $display("FAIL prescale3_period got %0d want 45", gap3);
          end
        end
        seen3 = 1;
        gap3  = 0;
      end
    end
  end

  initial begin
    bus.load   = 1'b0;
    bus.dutyIn = '0;
    bus.modeIn = '0;
    repeat (3) cycle(1'b0, '0, '0, 1'b1);
    @(negedge clk);
    tests++;
    if (bus.periodStart !== 1'b0 || bus.rLED !== '0 || bus.gLED !== '0 || bus.bLED !== '0) begin
      fails++;
      $display("FAIL reset_state got ps=%b r=%b g=%b b=%b want all 0",
               bus.periodStart, bus.rLED, bus.gLED, bus.bLED);
    end

    // LED0 R=0 G=15 B=5 static; LED1 full duty but off.
    load_at(3, 24'hFFF_5F0, 4'b1100);
    idle(3 * PER);
    // Two loads within one period: only the later one applies.
    load_at(7, 24'hFFF_5F3, 4'b1100);
    load_at(10, 24'hFFF_5F9, 4'b1100);
    idle(2 * PER);
    // Load on the boundary cycle is bypassed into the next period.
    load_at(14, 24'hFFF_5FC, 4'b1100);
    idle(2 * PER);
    // Blink LED0 red, LED1 static.
    load_at(5, 24'hC27_00F, 4'b0001);
    idle(8 * PER);
    // Breathe LED0 red through a full envelope cycle.
    load_at(5, 24'hC27_00F, 4'b0010);
    idle(34 * PER);

    random_run(40 * PER);

    // Reset mid-period with everything lit.
    load_at(2, 24'hFFF_FFF, 4'b0000);
    idle(PER);
    while (pos != 6) idle(1);
    cycle(1'b0, bus.dutyIn, bus.modeIn, 1'b1);
    idle(3 * PER);

    random_run(20 * PER);

    @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL pending_periods got %0d want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
